// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if: request/grant bundle between the IO bus arbiter and the
// peripheral masters. The master modport is the arbiter's view because it
// drives the grant lines. The slave modport is the requesters' view.
interface io_bus_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) ();
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  rel;
    logic [NUM_REQ-1:0]  BG;
    logic [ID_WIDTH-1:0] grant_id;
    logic                busy;
    logic                timeout_err;

    modport master (
        input  req,
        input  rel,
        output BG,
        output grant_id,
        output busy,
        output timeout_err
    );

    modport slave (
        output req,
        output rel,
        input  BG,
        input  grant_id,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin owner arbitration for the shared tristate IO bus.
// Bus grants are one-hot and registered. A single dead cycle (TURN) separates
// two owners so that their data drivers never overlap.
// Optional feature macro: IO_ARB_TIMEOUT_EN. When it is defined, a tenure
// counter revokes the grant after TIMEOUT_CYCLES cycles and pulses timeout_err.
module io_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TMO_WIDTH      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    io_bus_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Reject parameter sets that cannot be represented, at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("io_bus_arbiter: NUM_REQ must be 2..8");
    end
    if ((1 << ID_WIDTH) < NUM_REQ) begin : g_bad_id_width
        $error("io_bus_arbiter: ID_WIDTH too narrow for NUM_REQ");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TMO_WIDTH)) begin : g_bad_tmo
        $error("io_bus_arbiter: TMO_WIDTH cannot hold TIMEOUT_CYCLES");
    end

    state_t              state_q, state_nxt;
    logic [NUM_REQ-1:0]  bg_q, bg_nxt;
    logic [ID_WIDTH-1:0] id_q, id_nxt;
    logic [ID_WIDTH-1:0] ptr_q, ptr_nxt;
    logic                busy_q;
    logic                owner_rel;
    logic                owner_req;
    logic [ID_WIDTH-1:0] winner;

`ifdef IO_ARB_TIMEOUT_EN
    logic [TMO_WIDTH-1:0] ten_q, ten_nxt;
    logic                 tmo_q, tmo_nxt;
    logic                 expired;
`endif

    // Search starts one past the last owner and wraps, so the previous owner
    // ends up with the lowest priority.
    function automatic logic [ID_WIDTH-1:0] rr_pick(
        input logic [NUM_REQ-1:0]  r,
        input logic [ID_WIDTH-1:0] ptr
    );
        logic [ID_WIDTH-1:0] win;
        logic                found;
        int                  idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && (|(r & (NUM_REQ'(1) << idx)))) begin
                win   = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // BG is one-hot during a tenure, so masking with it selects the owner's
    // bits. Bits from non-owners cannot affect the result.
    assign owner_rel = |(bus.rel & bg_q);
    assign owner_req = |(bus.req & bg_q);
    assign winner    = rr_pick(bus.req, ptr_q);

`ifdef IO_ARB_TIMEOUT_EN
    assign expired = (ten_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, grant and tenure decisions.
    always_comb begin
        state_nxt = state_q;
        bg_nxt    = bg_q;
        id_nxt    = id_q;
        ptr_nxt   = ptr_q;
`ifdef IO_ARB_TIMEOUT_EN
        ten_nxt   = ten_q;
        tmo_nxt   = 1'b0;
`endif
        unique case (state_q)
            IDLE, TURN: begin
                if (|bus.req) begin
                    state_nxt = GRANT;
                    bg_nxt    = NUM_REQ'(1) << winner;
                    id_nxt    = winner;
`ifdef IO_ARB_TIMEOUT_EN
                    ten_nxt   = '0;
`endif
                end else begin
                    state_nxt = IDLE;
                    bg_nxt    = '0;
                end
            end
            GRANT: begin
                // A dropped request is treated the same as a release.
                if (owner_rel || !owner_req) begin
                    state_nxt = TURN;
                    bg_nxt    = '0;
                    ptr_nxt   = id_q;
`ifdef IO_ARB_TIMEOUT_EN
                end else if (expired) begin
                    state_nxt = TURN;
                    bg_nxt    = '0;
                    ptr_nxt   = id_q;
                    tmo_nxt   = 1'b1;
                end else begin
                    ten_nxt   = ten_q + TMO_WIDTH'(1);
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                bg_nxt    = '0;
            end
        endcase
    end

    // Registered state and outputs. Reset clears the grant asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bg_q    <= '0;
            id_q    <= '0;
            ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            bg_q    <= bg_nxt;
            id_q    <= id_nxt;
            ptr_q   <= ptr_nxt;
            busy_q  <= |bg_nxt;
        end
    end

`ifdef IO_ARB_TIMEOUT_EN
    // Tenure counter and the one-cycle revocation pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ten_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            ten_q <= ten_nxt;
            tmo_q <= tmo_nxt;
        end
    end

    assign bus.timeout_err = tmo_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.BG       = bg_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed scenarios and randomized traffic for
// io_bus_arbiter. The reference model tracks only the current owner, the last
// owner and the tenure length. It derives grants from the round-robin rules.
module tb_io_bus_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;
`ifdef IO_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;

    io_bus_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(2)) bus ();

    io_bus_arbiter #(
        .NUM_REQ(N),
        .ID_WIDTH(2),
        .TIMEOUT_CYCLES(TMO),
        .TMO_WIDTH(9)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model state: owner index (-1 when the bus is free), last owner, last
    // granted id, tenure cycles so far, and the expected timeout pulse.
    int m_owner;
    int m_last;
    int m_id;
    int m_ten;
    bit m_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return |(v & (N'(1) << i));
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_id    = 0;
        m_ten   = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        m_tmo = 1'b0;
        if (m_owner >= 0) begin
            if (bit_of(l, m_owner) || !bit_of(r, m_owner)) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (TMO_ON && m_ten == TMO - 1) begin
                m_last  = m_owner;
                m_owner = -1;
                m_tmo   = 1'b1;
            end else begin
                m_ten++;
            end
        end else if (r != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && bit_of(r, (m_last + k) % N)) begin
                    m_owner = (m_last + k) % N;
                    m_id    = m_owner;
                    m_ten   = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] exp_bg;
        exp_bg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk({tag, ".BG"}, 32'(bus.BG), 32'(exp_bg));
        chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(m_id));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_owner >= 0));
        chk({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(m_tmo));
    endtask

    // Drive one cycle of inputs at the falling edge. Update the model at the
    // rising edge and compare shortly after it.
    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] l);
        bus.req = r;
        bus.rel = l;
        @(posedge clk);
        model_step(r, l);
        #1;
        check_all("cyc");
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        bus.rel = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("rst.BG", 32'(bus.BG), 32'h0);
        chk("rst.grant_id", 32'(bus.grant_id), 32'h0);
        chk("rst.busy", 32'(bus.busy), 32'h0);
        chk("rst.timeout_err", 32'(bus.timeout_err), 32'h0);
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] r;
        logic [N-1:0] l;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b1;
        bus.req = '0;
        bus.rel = '0;
        model_reset();

        // A single request is granted with one cycle of latency, and a release
        // returns the arbiter to idle.
        do_reset();
        tick(4'b0001, 4'b0000);
        chk("single.BG", 32'(bus.BG), 32'h1);
        chk("single.id", 32'(bus.grant_id), 32'h0);
        chk("single.busy", 32'(bus.busy), 32'h1);
        tick(4'b0001, 4'b0001);
        chk("single.rel", 32'(bus.BG), 32'h0);
        tick(4'b0000, 4'b0000);
        chk("single.idle", 32'(bus.busy), 32'h0);

        // All four request. Each owner holds for 3 cycles, with one dead cycle
        // between owners.
        do_reset();
        tick(4'b1111, 4'b0000);
        for (int g = 0; g < 5; g++) begin
            chk("rr.order", 32'(bus.BG), 32'(4'b0001 << order[g]));
            tick(4'b1111, 4'b0000);
            tick(4'b1111, 4'b0000);
            tick(4'b1111, 4'b0001 << order[g]);
            chk("rr.gap", 32'(bus.BG), 32'h0);
            tick(4'b1111, 4'b0000);
        end

        // Owner 2 releases while requesters 3, 2 and 0 are pending. Requester 3
        // is next, then requester 0.
        do_reset();
        tick(4'b0100, 4'b0000);
        tick(4'b1101, 4'b0100);
        tick(4'b1101, 4'b0000);
        chk("rr.skip_to_3", 32'(bus.BG), 32'h8);
        tick(4'b0101, 4'b1000);
        tick(4'b0101, 4'b0000);
        chk("rr.wrap_to_0", 32'(bus.BG), 32'h1);

        // Owner 1 releases but keeps its request high. It drops to the lowest
        // priority, so requester 3 wins.
        do_reset();
        tick(4'b0010, 4'b0000);
        tick(4'b1010, 4'b0010);
        tick(4'b1010, 4'b0000);
        chk("rel_hold.BG", 32'(bus.BG), 32'h8);

        // Owner 0 drops its request without a release pulse.
        do_reset();
        tick(4'b0001, 4'b0000);
        tick(4'b0010, 4'b0000);
        chk("drop.BG", 32'(bus.BG), 32'h0);
        tick(4'b0010, 4'b0000);
        chk("drop.next", 32'(bus.BG), 32'h2);

        // Reset during a tenure clears BG before the next clock edge.
        do_reset();
        tick(4'b0001, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.BG", 32'(bus.BG), 32'h0);
        chk("async_rst.busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Owner holds the bus without releasing. The grant is revoked after
        // TMO cycles when the timeout is built; otherwise it is held indefinitely.
        do_reset();
        tick(4'b0001, 4'b0000);
        for (int i = 0; i < TMO - 1; i++) begin
            tick(4'b0001, 4'b0000);
            chk("hold.BG", 32'(bus.BG), 32'h1);
        end
        tick(4'b0001, 4'b0000);
        chk("hold.end_BG", 32'(bus.BG), TMO_ON ? 32'h0 : 32'h1);
        chk("hold.tmo", 32'(bus.timeout_err), TMO_ON ? 32'h1 : 32'h0);
        chk("hold.id", 32'(bus.grant_id), 32'h0);
        tick(4'b0001, 4'b0000);
        chk("hold.tmo_clear", 32'(bus.timeout_err), 32'h0);

        // Randomized traffic. Requests stay up until served; non-owners emit
        // stray releases; owners release, drop, or hold at random.
        do_reset();
        r = '0;
        for (int c = 0; c < 2000; c++) begin
            l = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) r = r | (N'(1) << b);
                if (b != m_owner && $urandom_range(0, 7) == 0) l = l | (N'(1) << b);
            end
            if (m_owner >= 0) begin
                case ($urandom_range(0, 7))
                    0, 1:    l = l | (N'(1) << m_owner);
                    2:       r = r & ~(N'(1) << m_owner);
                    default: ;
                endcase
            end
            tick(r, l);
            if (m_owner < 0 && $urandom_range(0, 1) == 0) r = r & ~(N'(1) << m_last);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
